// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-client round-robin arbiter with one outstanding memory transaction
// Port 0 carries instruction fetch, port 1 carries data load/store.
// Ports:
//   clk, reset (synchronous, active-low)
//   cN_req_{type,address,data,length,valid} in / cN_req_ready out   client request, N=0,1
//   cN_resp_{address,data,valid} out / cN_resp_ready in            client response
//   mem_req_{type,address,data,length,valid} out / mem_req_ready in  memory request (registered)
//   mem_resp_{address,data,valid} in / mem_resp_ready out            memory response (registered ready)
//   err_timeout out: sticky watchdog flag, only active when ARB_TIMEOUT_EN is defined
module mem_port_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            c0_req_type,
  input  logic [XLEN-1:0] c0_req_address,
  input  logic [XLEN-1:0] c0_req_data,
  input  logic [1:0]      c0_req_length,
  input  logic            c0_req_valid,
  output logic            c0_req_ready,
  output logic [XLEN-1:0] c0_resp_address,
  output logic [XLEN-1:0] c0_resp_data,
  output logic            c0_resp_valid,
  input  logic            c0_resp_ready,
  input  logic            c1_req_type,
  input  logic [XLEN-1:0] c1_req_address,
  input  logic [XLEN-1:0] c1_req_data,
  input  logic [1:0]      c1_req_length,
  input  logic            c1_req_valid,
  output logic            c1_req_ready,
  output logic [XLEN-1:0] c1_resp_address,
  output logic [XLEN-1:0] c1_resp_data,
  output logic            c1_resp_valid,
  input  logic            c1_resp_ready,
  output logic            mem_req_type,
  output logic [XLEN-1:0] mem_req_address,
  output logic [XLEN-1:0] mem_req_data,
  output logic [1:0]      mem_req_length,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  input  logic [XLEN-1:0] mem_resp_address,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  output logic            err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
  state_t          state_q;
  logic            last_q, owner_q, gnt_d, acc_d;
  logic            mem_req_type_q, mem_req_valid_q, mem_resp_ready_q;
  logic [XLEN-1:0] mem_req_address_q, mem_req_data_q;
  logic [1:0]      mem_req_length_q;
  logic            c0_resp_valid_q, c1_resp_valid_q;
  logic [XLEN-1:0] c0_resp_address_q, c0_resp_data_q, c1_resp_address_q, c1_resp_data_q;
  // A lone requester wins outright; a tie or no request points at the port not granted last.
  always_comb begin
    gnt_d = (c0_req_valid ^ c1_req_valid) ? c1_req_valid : ~last_q;
    acc_d = (state_q == IDLE) && (gnt_d ? c1_req_valid : c0_req_valid);
  end
  assign c0_req_ready    = (state_q == IDLE) && !gnt_d;
  assign c1_req_ready    = (state_q == IDLE) && gnt_d;
  assign mem_req_type    = mem_req_type_q;
  assign mem_req_address = mem_req_address_q;
  assign mem_req_data    = mem_req_data_q;
  assign mem_req_length  = mem_req_length_q;
  assign mem_req_valid   = mem_req_valid_q;
  assign mem_resp_ready  = mem_resp_ready_q;
  assign c0_resp_address = c0_resp_address_q;
  assign c0_resp_data    = c0_resp_data_q;
  assign c0_resp_valid   = c0_resp_valid_q;
  assign c1_resp_address = c1_resp_address_q;
  assign c1_resp_data    = c1_resp_data_q;
  assign c1_resp_valid   = c1_resp_valid_q;
  always_ff @(posedge clk)
    if (!reset) begin
      state_q           <= IDLE;
      last_q            <= 1'b1;
      owner_q           <= 1'b0;
      mem_req_type_q    <= 1'b0;
      mem_req_address_q <= '0;
      mem_req_data_q    <= '0;
      mem_req_length_q  <= '0;
      mem_req_valid_q   <= 1'b0;
      mem_resp_ready_q  <= 1'b0;
      c0_resp_valid_q   <= 1'b0;
      c1_resp_valid_q   <= 1'b0;
      c0_resp_address_q <= '0;
      c0_resp_data_q    <= '0;
      c1_resp_address_q <= '0;
      c1_resp_data_q    <= '0;
    end else
      case (state_q)
        IDLE: if (acc_d) begin
          mem_req_type_q    <= gnt_d ? c1_req_type : c0_req_type;
          mem_req_address_q <= gnt_d ? c1_req_address : c0_req_address;
          mem_req_data_q    <= gnt_d ? c1_req_data : c0_req_data;
          mem_req_length_q  <= gnt_d ? c1_req_length : c0_req_length;
          mem_req_valid_q   <= 1'b1;
          owner_q           <= gnt_d;
          last_q            <= gnt_d;
          state_q           <= ISSUE;
        end
        ISSUE: if (mem_req_ready) begin
          mem_req_valid_q  <= 1'b0;
          mem_resp_ready_q <= 1'b1;
          state_q          <= WAIT;
        end
        WAIT: if (mem_resp_valid) begin
          mem_resp_ready_q <= 1'b0;
          if (owner_q) begin
            c1_resp_address_q <= mem_resp_address;
            c1_resp_data_q    <= mem_resp_data;
            c1_resp_valid_q   <= 1'b1;
          end else begin
            c0_resp_address_q <= mem_resp_address;
            c0_resp_data_q    <= mem_resp_data;
            c0_resp_valid_q   <= 1'b1;
          end
          state_q <= RETURN;
        end
        default: if (owner_q ? c1_resp_ready : c0_resp_ready) begin
          c0_resp_valid_q <= 1'b0;
          c1_resp_valid_q <= 1'b0;
          state_q         <= IDLE;
        end
      endcase
`ifdef ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        err_q;
  // The flag only reports a stuck memory; the FSM keeps waiting regardless.
  always_ff @(posedge clk)
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (state_q == ISSUE && mem_req_ready)
      wait_cnt_q <= '0;
    else if (state_q == WAIT && !mem_resp_valid) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
      if (wait_cnt_q == 32'd1023) err_q <= 1'b1;
    end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-client request arbiter placed directly upstream of the data-memory model; it drives that model's req/resp handshake.
- Port 0 serves instruction fetch and port 1 serves data load/store. Each client gets its own req/resp valid-ready interface.
- Allows one outstanding transaction at a time, with round-robin grant.
- All memory-side request and response outputs come straight from registers.

Parameters:
- XLEN, 64, address/data width; matches coreparam::XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- c0_req_type / c1_req_type  in  1  coreparam memoryRead/memoryWrite encoding
- c0_req_address / c1_req_address  in  XLEN  byte address
- c0_req_data / c1_req_data  in  XLEN  write data
- c0_req_length / c1_req_length  in  2  log2 of byte count (0..3)
- c0_req_valid / c1_req_valid  in  1  request valid
- c0_req_ready / c1_req_ready  out  1  request accepted
- c0_resp_address / c1_resp_address  out  XLEN  returned address
- c0_resp_data / c1_resp_data  out  XLEN  returned data
- c0_resp_valid / c1_resp_valid  out  1  response valid
- c0_resp_ready / c1_resp_ready  in  1  client takes response
- mem_req_type  out  1  forwarded type
- mem_req_address  out  XLEN  forwarded address
- mem_req_data  out  XLEN  forwarded data
- mem_req_length  out  2  forwarded length
- mem_req_valid  out  1  request valid to memory
- mem_req_ready  in  1  memory accepts request
- mem_resp_address  in  XLEN  memory response address
- mem_resp_data  in  XLEN  memory response data
- mem_resp_valid  in  1  memory response valid
- mem_resp_ready  out  1  arbiter takes response
- err_timeout  out  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- States:
  - IDLE: accepting a client request.
  - ISSUE: mem_req_valid=1.
  - WAIT: mem_resp_ready=1.
  - RETURN: cN_resp_valid=1 for the owner only.
- Reset (reset==0 at posedge):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All valid/ready outputs 0 except as derived from IDLE.
  - Registered address/data outputs cleared to 0.
  - err_timeout=0.
  - Reset mid-transaction abandons it; no response is delivered. Memory-side reset is the integrator's concern.
- Grant, IDLE only:
  - Exactly one of cN_req_ready is 1, combinationally.
  - Only port 0 valid: grant 0.
  - Only port 1 valid: grant 1.
  - Both valid: grant the port != last_grant.
  - Neither valid: ready follows the round-robin choice, i.e. port != last_grant.
- Accept (cN_req_valid && cN_req_ready):
  - Latch type, address, data and length into mem_req_* registers.
  - owner<=N, last_grant<=N, state<=ISSUE.
  - mem_req_valid rises on the next cycle (1-cycle issue latency).
- ISSUE:
  - mem_req_* held stable until mem_req_ready.
  - On handshake: state<=WAIT, mem_req_valid<=0.
- WAIT:
  - mem_resp_ready=1.
  - On mem_resp_valid: capture address and data into the owner's resp registers, state<=RETURN.
  - Response is taken in the same cycle it is valid.
- RETURN:
  - c[owner]_resp_valid=1; the other port's resp_valid stays 0.
  - Held until c[owner]_resp_ready, then state<=IDLE.
  - A new request may be accepted no earlier than the following cycle.
- Simultaneous events:
  - Client requests arriving outside IDLE see ready=0 and must hold.
  - A mem_resp_valid arriving outside WAIT is not accepted (mem_resp_ready=0).
- Write responses: returned like reads; resp_data carries whatever memory presents, and clients ignore it for writes.
- No width conversion: length and data pass unchanged.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro: a 32-bit counter clears on entry to WAIT and increments each WAIT cycle. If it reaches 1024 before mem_resp_valid, err_timeout<=1 (sticky until reset). The state machine keeps waiting, with no abort.
- Without the macro: err_timeout is tied 0 and no counter logic exists.

Test Plan:
- Port 0 only: read at 0x1000, memory acks after 6 cycles with data 0xDEADBEEF -> mem_req_valid rises 1 cycle after accept; c0_resp_valid=1 with addr 0x1000, data 0xDEADBEEF; c1_resp_valid stays 0.
- Both ports valid in the same cycle out of reset -> port 0 served first. Port 1, held valid, is granted next; mem_req_address order is 0x2000 (c0) then 0x3000 (c1).
- Port 1 write of 0x11223344 at 0x40, length 2 -> mem_req_type=memoryWrite, mem_req_length=2, data unchanged; c1_resp_valid asserted once with addr 0x40.
- Backpressure: mem_req_ready held low 4 cycles, then c0_resp_ready held low 3 cycles -> mem_req_* and c0_resp_* stable throughout; both cN_req_ready stay 0 until back in IDLE.
- Reset asserted low during WAIT -> next cycle state IDLE, all resp_valid 0. A subsequent c0 read completes normally.
- With ARB_TIMEOUT_EN and no memory response for 1100 cycles -> err_timeout=1 at WAIT cycle 1024 and stays set. Without the macro, err_timeout remains 0.
